// File: rtl/clock_set_ctrl_if.sv
// Counter-side bus of the clock set controller: live time in, run/load controls out.
// master = controller (clock_set_ctrl), slave = time counter.
interface clock_set_ctrl_if;
    logic [5:0] cur_hr;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       run_en;
    logic       ld;
    logic [5:0] ld_hr;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;

    modport master (
        input  cur_hr, cur_min, cur_sec,
        output run_en, ld, ld_hr, ld_min, ld_sec
    );

    modport slave (
        output cur_hr, cur_min, cur_sec,
        input  run_en, ld, ld_hr, ld_min, ld_sec
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Clock time/alarm setting FSM driven by mode/inc buttons; loads the time counter on COMMIT.
// Optional alarm states and alarm output are compiled in with `define CLOCK_SET_ALARM_EN.
module clock_set_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int HR_MOD  = 24,
    parameter int MIN_MOD = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  mode_btn,
    input  logic                  inc_btn,
    clock_set_ctrl_if.master      bus,
    output logic [5:0]            disp_hr,
    output logic [5:0]            disp_min,
    output logic [2:0]            state_o,
    output logic                  alarm_out
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_AHR  = 3'd3,
        SET_AMIN = 3'd4,
        COMMIT   = 3'd5
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state, state_nxt;
    logic           mode_q, inc_q;
    logic           mode_e, inc_raw, inc_e;
    logic           in_set, tmo_hit;
    logic [TW-1:0]  tmo_cnt;
    logic [5:0]     edit_hr, edit_min;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input int m);
        return (v == 6'(m - 1)) ? 6'd0 : v + 6'd1;
    endfunction

    // Previous-cycle samples start high so a button held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b1;
            inc_q  <= 1'b1;
        end else begin
            mode_q <= mode_btn;
            inc_q  <= inc_btn;
        end
    end

    assign mode_e  = mode_btn & ~mode_q;
    assign inc_raw = inc_btn & ~inc_q;
    assign inc_e   = inc_raw & ~mode_e;
    assign in_set  = (state != RUN) && (state != COMMIT);
    assign tmo_hit = in_set && tick && !mode_e && !inc_raw && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mode_e) state_nxt = SET_HR;
            SET_HR:   if (mode_e) state_nxt = SET_MIN;
                      else if (tmo_hit) state_nxt = RUN;
`ifdef CLOCK_SET_ALARM_EN
            SET_MIN:  if (mode_e) state_nxt = SET_AHR;
                      else if (tmo_hit) state_nxt = RUN;
            SET_AHR:  if (mode_e) state_nxt = SET_AMIN;
                      else if (tmo_hit) state_nxt = RUN;
            SET_AMIN: if (mode_e) state_nxt = COMMIT;
                      else if (tmo_hit) state_nxt = RUN;
`else
            SET_MIN:  if (mode_e) state_nxt = COMMIT;
                      else if (tmo_hit) state_nxt = RUN;
`endif
            COMMIT:   state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!in_set || mode_e || inc_raw) begin
            tmo_cnt <= '0;
        end else if (tick) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edit_hr  <= 6'd0;
            edit_min <= 6'd0;
        end else if (state == RUN && mode_e) begin
            edit_hr  <= bus.cur_hr;
            edit_min <= bus.cur_min;
        end else if (state == SET_HR && inc_e) begin
            edit_hr  <= wrap_inc(edit_hr, HR_MOD);
        end else if (state == SET_MIN && inc_e) begin
            edit_min <= wrap_inc(edit_min, MIN_MOD);
        end
    end

`ifdef CLOCK_SET_ALARM_EN
    logic [5:0] alm_hr, alm_min, alm_tk;
    logic       alm_vld, match, match_q, alm_fire;

    assign match = alm_vld && (state == RUN) && (bus.cur_hr == alm_hr)
                && (bus.cur_min == alm_min) && (bus.cur_sec == 6'd0);

    // Fire only on the first cycle of a match so a cleared alarm stays quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            alm_hr   <= 6'd0;
            alm_min  <= 6'd0;
            alm_vld  <= 1'b0;
            match_q  <= 1'b0;
            alm_fire <= 1'b0;
            alm_tk   <= 6'd0;
        end else begin
            if (state == SET_AHR && inc_e)  alm_hr  <= wrap_inc(alm_hr, HR_MOD);
            if (state == SET_AMIN && inc_e) alm_min <= wrap_inc(alm_min, MIN_MOD);
            if (state == COMMIT)            alm_vld <= 1'b1;
            match_q <= match;
            if (mode_e || inc_raw) begin
                alm_fire <= 1'b0;
                alm_tk   <= 6'd0;
            end else if (match && !match_q) begin
                alm_fire <= 1'b1;
                alm_tk   <= 6'd0;
            end else if (alm_fire && tick) begin
                if (alm_tk == 6'd59) alm_fire <= 1'b0;
                else                 alm_tk   <= alm_tk + 6'd1;
            end
        end
    end

    assign alarm_out = alm_fire;
`else
    logic unused_sec;
    assign unused_sec = ^bus.cur_sec;
    assign alarm_out  = 1'b0;
`endif

    // Load is suppressed while reset is asserted so an aborted COMMIT never strobes.
    always_comb begin
        bus.run_en = (state == RUN);
        bus.ld     = (state == COMMIT) && !rst;
        bus.ld_hr  = bus.ld ? edit_hr  : 6'd0;
        bus.ld_min = bus.ld ? edit_min : 6'd0;
        bus.ld_sec = 6'd0;
        state_o    = state;
        disp_hr    = edit_hr;
        disp_min   = edit_min;
        case (state)
            RUN: begin
                disp_hr  = bus.cur_hr;
                disp_min = bus.cur_min;
            end
`ifdef CLOCK_SET_ALARM_EN
            SET_AHR, SET_AMIN: begin
                disp_hr  = alm_hr;
                disp_min = alm_min;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl; load strobes checked by a scoreboard monitor.
// Alarm scenarios run only when CLOCK_SET_ALARM_EN is defined.
module tb_clock_set_ctrl;
    logic       clk = 1'b0;
    logic       rst, tick, mode_btn, inc_btn;
    logic [5:0] disp_hr, disp_min;
    logic [2:0] state_o;
    logic       alarm_out;

    clock_set_ctrl_if bus();

    clock_set_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .bus       (bus),
        .disp_hr   (disp_hr),
        .disp_min  (disp_min),
        .state_o   (state_o),
        .alarm_out (alarm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hr;
        int min;
        int sec;
    } ld_exp_t;

    ld_exp_t ld_q[$];
    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Every ld cycle must match one queued expectation; extra cycles are failures.
    always @(negedge clk) begin
        if (bus.ld === 1'b1) begin
            if (ld_q.size() == 0) begin
                check("ld_unexpected", 1, 0);
            end else begin
                ld_exp_t e;
                e = ld_q.pop_front();
                check("ld_hr",  int'(bus.ld_hr),  e.hr);
                check("ld_min", int'(bus.ld_min), e.min);
                check("ld_sec", int'(bus.ld_sec), e.sec);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; cyc(1);
        mode_btn = 1'b0; cyc(1);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            inc_btn = 1'b1; cyc(1);
            inc_btn = 1'b0; cyc(1);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cyc(1);
            tick = 1'b0; cyc(1);
        end
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus.cur_hr  = 6'(h);
        bus.cur_min = 6'(m);
        bus.cur_sec = 6'(s);
    endtask

    // From SET_MIN: walk through any alarm states, then commit with the given load values.
    task automatic commit_from_min(input int h, input int m);
        ld_exp_t e;
`ifdef CLOCK_SET_ALARM_EN
        press_mode(); check("seq_ahr", int'(state_o), 3);
        press_mode(); check("seq_amin", int'(state_o), 4);
`endif
        e.hr = h; e.min = m; e.sec = 0;
        ld_q.push_back(e);
        press_mode();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        set_cur(0, 0, 0);
        cyc(2);
        rst = 1'b0;
        set_cur(12, 34, 0);
        cyc(1);
        check("rst_state",  int'(state_o), 0);
        check("rst_run_en", int'(bus.run_en), 1);
        check("rst_ld",     int'(bus.ld), 0);
        check("rst_alarm",  int'(alarm_out), 0);
        check("idle_disp_hr",  int'(disp_hr), 12);
        check("idle_disp_min", int'(disp_min), 34);
        set_cur(5, 6, 0);
        cyc(1);
        check("track_disp_hr",  int'(disp_hr), 5);
        check("track_disp_min", int'(disp_min), 6);

        // Time set from 10:59 -> 00:01
        set_cur(10, 59, 0);
        press_mode();
        check("set_hr_state", int'(state_o), 1);
        check("set_hr_run_en", int'(bus.run_en), 0);
        check("capture_hr", int'(disp_hr), 10);
        check("capture_min", int'(disp_min), 59);
        press_inc(14);
        check("hr_wrap", int'(disp_hr), 0);
        press_mode();
        check("set_min_state", int'(state_o), 2);
        press_inc(2);
        check("min_wrap", int'(disp_min), 1);
        check("min_keeps_hr", int'(disp_hr), 0);
        commit_from_min(0, 1);
        check("post_commit_state", int'(state_o), 0);
        check("post_commit_run_en", int'(bus.run_en), 1);

        // Simultaneous mode+inc in SET_HR: mode wins
        press_mode();
        mode_btn = 1'b1; inc_btn = 1'b1; cyc(1);
        mode_btn = 1'b0; inc_btn = 1'b0; cyc(1);
        check("simul_state", int'(state_o), 2);
        check("simul_hr", int'(disp_hr), 10);

        // Timeout boundary: 29 ticks stays, 30th aborts
        ticks(29);
        check("tmo_29", int'(state_o), 2);
        ticks(1);
        check("tmo_30", int'(state_o), 0);

        // An inc edge restarts the timeout
        press_mode(); press_mode();
        ticks(29);
        press_inc(1);
        check("tmo_inc_hold", int'(state_o), 2);
        ticks(29);
        check("tmo_restart_29", int'(state_o), 2);
        ticks(1);
        check("tmo_restart_30", int'(state_o), 0);

        // Reset deep in the sequence, with mode held high across it
        press_mode(); press_mode();
`ifdef CLOCK_SET_ALARM_EN
        press_mode(); press_mode();
        check("pre_rst_amin", int'(state_o), 4);
`else
        check("pre_rst_min", int'(state_o), 2);
`endif
        rst = 1'b1; mode_btn = 1'b1; cyc(2);
        check("rst_mid_state", int'(state_o), 0);
        rst = 1'b0; cyc(2);
        check("held_mode_no_edge", int'(state_o), 0);
        mode_btn = 1'b0; cyc(2);
        check("release_mode_idle", int'(state_o), 0);

        // Reset asserted while in COMMIT: no load strobe
        press_mode(); press_mode();
`ifdef CLOCK_SET_ALARM_EN
        press_mode(); press_mode();
`endif
        mode_btn = 1'b1; cyc(1);
        mode_btn = 1'b0; rst = 1'b1; #1;
        check("in_commit", int'(state_o), 5);
        check("ld_masked_by_rst", int'(bus.ld), 0);
        cyc(1);
        check("commit_rst_state", int'(state_o), 0);
        rst = 1'b0; cyc(2);
        check("commit_rst_idle", int'(state_o), 0);

`ifdef CLOCK_SET_ALARM_EN
        // Alarm 07:30, then match at 07:30:00 in RUN
        set_cur(10, 59, 0);
        press_mode(); press_mode(); press_mode();
        check("ahr_disp", int'(disp_hr), 0);
        press_inc(7);
        press_mode();
        press_inc(30);
        check("amin_state", int'(state_o), 4);
        check("alm_disp_hr", int'(disp_hr), 7);
        check("alm_disp_min", int'(disp_min), 30);
        begin
            ld_exp_t e;
            e.hr = 10; e.min = 59; e.sec = 0;
            ld_q.push_back(e);
        end
        press_mode();
        check("alm_commit_run", int'(state_o), 0);
        check("alm_quiet", int'(alarm_out), 0);
        set_cur(7, 30, 0);
        cyc(1);
        check("alm_fire", int'(alarm_out), 1);
        inc_btn = 1'b1; cyc(1);
        check("alm_clear_inc", int'(alarm_out), 0);
        inc_btn = 1'b0; cyc(2);
        check("alm_no_refire", int'(alarm_out), 0);
        check("inc_in_run_ignored", int'(state_o), 0);
`endif

        cyc(2);
        check("ld_pending", ld_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 30, number of tick pulses with no button edge before a set sequence aborts.
REQ-002 Parameter: HR_MOD, default 24, hour wrap modulus.
REQ-003 Parameter: MIN_MOD, default 60, minute wrap modulus.
REQ-004 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: tick  input  1  one-cycle 1 Hz enable, shared with the time counter.
REQ-007 Port: mode_btn  input  1  debounced level; its rising edge advances the mode.
REQ-008 Port: inc_btn  input  1  debounced level; its rising edge increments the field being edited.
REQ-009 Port: cur_hr, cur_min, cur_sec  input  6 each  live time from the counter.
REQ-010 Port: run_en  output  1  counter count enable.
REQ-011 Port: ld  output  1  one-cycle load strobe to the counter.
REQ-012 Port: ld_hr, ld_min, ld_sec  output  6 each  load values, valid when ld=1.
REQ-013 Port: disp_hr, disp_min  output  6 each  values for display.
REQ-014 Port: state_o  output  3  current state encoding.
REQ-015 Port: alarm_out  output  1  alarm indication.

Function
REQ-016 States and encodings: RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4, COMMIT=5; state_o equals the state.
REQ-017 Edges: btn_edge = btn & ~btn_q, where btn_q is the previous-cycle sample; state acts on the same rising edge at which the edge is sampled.
REQ-018 RUN -> SET_HR on mode edge; the same edge captures edit_hr=cur_hr and edit_min=cur_min.
REQ-019 Mode-edge sequence with the alarm feature compiled in: SET_HR -> SET_MIN -> SET_AHR -> SET_AMIN -> COMMIT.
REQ-020 Mode-edge sequence with the alarm feature compiled out: SET_HR -> SET_MIN -> COMMIT.
REQ-021 COMMIT lasts exactly one cycle, then goes to RUN.
REQ-022 In COMMIT: ld=1, ld_hr=edit_hr, ld_min=edit_min, ld_sec=0; ld is 0 in every other state.
REQ-023 Increment rules: an inc edge adds 1 to the field of the current set state; hours wrap HR_MOD-1 -> 0, minutes wrap MIN_MOD-1 -> 0; no other field changes.
REQ-024 An inc edge in RUN or COMMIT is ignored.
REQ-025 Simultaneous mode and inc edges: mode wins and the inc edge is discarded.
REQ-026 run_en = 1 only in RUN, combinational from state; the counter is frozen during set states and COMMIT.
REQ-027 Display: RUN shows disp_hr/min = cur_hr/min; SET_HR/SET_MIN/COMMIT show edit_hr/min; SET_AHR/SET_AMIN show alm_hr/min.
REQ-028 Timeout counter: cleared on entry to any set state and on every button edge; increments on tick while in a set state.
REQ-029 When the timeout counter reaches TIMEOUT in a set state: go to RUN, no ld pulse, edit values discarded, alarm registers keep any edits.
REQ-030 tick in RUN or COMMIT has no effect on this block.

Reset
REQ-031 Reset values: rst=1 forces state=RUN, so run_en=1 and state_o=0.
REQ-032 Reset clears ld, ld_hr, ld_min, ld_sec, edit_hr, edit_min, alm_hr, alm_min, the alarm valid flag, the timeout counter and alarm_out to 0.
REQ-033 mode_btn_q and inc_btn_q reset to 1, so a button held through reset produces no edge.
REQ-034 Reset asserted mid-sequence, including in COMMIT, aborts with no ld pulse and takes priority over all edges.

Configuration
REQ-035 Macro CLOCK_SET_ALARM_EN defined: states SET_AHR/SET_AMIN, the alm_hr/alm_min registers (6-bit, same wrap rules) and the alarm valid flag are present.
REQ-036 Alarm valid flag: set on COMMIT.
REQ-037 alarm_out set in RUN when valid, cur_hr=alm_hr, cur_min=alm_min and cur_sec=0.
REQ-038 alarm_out clears on any button edge or after 60 ticks.
REQ-039 Macro CLOCK_SET_ALARM_EN undefined: alarm states and registers are absent, alarm_out is tied 0, and the sequence of REQ-020 applies.

Verification
REQ-040 Reset then idle: state_o=0, run_en=1, ld=0, alarm_out=0; disp_hr/min track cur_hr/min.
REQ-041 Time set with cur=10:59: mode, 14 inc, mode, 2 inc, then mode (macro off) or mode, mode, mode (macro on) -> single ld cycle with ld_hr=0, ld_min=1, ld_sec=0, then run_en=1.
REQ-042 Simultaneous edges: in SET_HR, mode and inc rise in the same cycle -> state=SET_MIN, edit_hr unchanged.
REQ-043 Timeout: enter SET_MIN, apply 30 ticks with no buttons -> state=RUN, no ld pulse; with 29 ticks plus one inc, state stays SET_MIN.
REQ-044 Alarm (macro on): set alarm 07:30 and commit; drive cur=07:30:00 in RUN -> alarm_out=1; an inc edge clears it the next cycle.
REQ-045 Reset in SET_AMIN, or mode_btn held high across reset -> state_o=0, ld never asserted, no spurious transition.
